// File: rtl/pcalc_issue.sv
// pcalc_issue: issue/collect wrapper around the pcalc datapath (pos = origin + t*dir).
// Rays are queued on entry, presented to pcalc one per 3-cycle v0/v1/v2 window,
// tracked through pcalc's fixed latency, and collected into a result FIFO whose
// free space is reserved in advance by issue credits, so results never overflow.
module pcalc_issue #(
  parameter int DEPTH     = 4,
  parameter int RES_DEPTH = 4,
  parameter int PCALC_LAT = 12,
  parameter int ID_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ray_valid,
  output logic              ray_ready,
  input  logic [191:0]      ray_in,
  input  logic [31:0]       t_in,
  input  logic [ID_W-1:0]   id_in,
  output logic [191:0]      pc_vec,
  output logic [31:0]       pc_t,
  output logic              v0,
  output logic              v1,
  output logic              v2,
  input  logic [95:0]       pc_pos,
  output logic              pos_valid,
  input  logic              pos_ready,
  output logic [95:0]       pos_out,
  output logic [ID_W-1:0]   pos_id
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(RES_DEPTH);

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2
  } phase_t;

  phase_t phase, phase_nxt;

  // input FIFO storage and bookkeeping
  logic [191:0]    in_vec [DEPTH];
  logic [31:0]     in_t   [DEPTH];
  logic [ID_W-1:0] in_id  [DEPTH];
  logic [AW-1:0]   in_wr, in_rd;
  logic [AW:0]     in_cnt;
  logic            in_full, in_empty, push;

  // issue state
  logic            issue, issue_tok;
  logic [ID_W-1:0] issue_id;
  logic [RW:0]     credit;

  // latency tracking pipeline, stage k holds the ray whose pos is valid k cycles after its v0
  logic [PCALC_LAT:1] tok_sr;
  logic [ID_W-1:0]    id_sr [1:PCALC_LAT];

  // result FIFO storage and bookkeeping
  logic [95:0]     res_pos [RES_DEPTH];
  logic [ID_W-1:0] res_idm [RES_DEPTH];
  logic [RW-1:0]   res_wr, res_rd;
  logic [RW:0]     res_cnt;
  logic            res_push, res_pop;

  assign in_full   = (in_cnt == (AW+1)'(DEPTH));
  assign in_empty  = (in_cnt == '0);
  assign ray_ready = !in_full;
  assign push      = ray_valid & ray_ready;

  // a ray is launched only from the last phase, and only if a result slot is reserved for it
  assign issue     = v2 & !in_empty & (credit != '0);

  assign res_push  = tok_sr[PCALC_LAT];
  assign pos_valid = (res_cnt != '0);
  assign res_pop   = pos_valid & pos_ready;
  assign pos_out   = pos_valid ? res_pos[res_rd] : '0;
  assign pos_id    = pos_valid ? res_idm[res_rd] : '0;

  // phase register; resets to phase 0 so v0 is high throughout reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) phase <= PH0;
    else      phase <= phase_nxt;
  end

  // phase sequencing and one-hot strobe decode
  always_comb begin
    phase_nxt = PH0;
    v0 = 1'b0;
    v1 = 1'b0;
    v2 = 1'b0;
    case (phase)
      PH0: begin v0 = 1'b1; phase_nxt = PH1; end
      PH1: begin v1 = 1'b1; phase_nxt = PH2; end
      PH2: begin v2 = 1'b1; phase_nxt = PH0; end
      default: begin v0 = 1'b1; phase_nxt = PH1; end
    endcase
  end

  // input FIFO data write; contents need no reset since occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (push) begin
      in_vec[in_wr] <= ray_in;
      in_t[in_wr]   <= t_in;
      in_id[in_wr]  <= id_in;
    end
  end

  // input FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_wr  <= '0;
      in_rd  <= '0;
      in_cnt <= '0;
    end else begin
      if (push)  in_wr <= in_wr + AW'(1);
      if (issue) in_rd <= in_rd + AW'(1);
      case ({push, issue})
        2'b10:   in_cnt <= in_cnt + (AW+1)'(1);
        2'b01:   in_cnt <= in_cnt - (AW+1)'(1);
        default: in_cnt <= in_cnt;
      endcase
    end
  end

  // issue decision at the end of phase 2; operands hold for the whole next window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_vec    <= '0;
      pc_t      <= '0;
      issue_id  <= '0;
      issue_tok <= 1'b0;
    end else if (v2) begin
      issue_tok <= issue;
      if (issue) begin
        pc_vec   <= in_vec[in_rd];
        pc_t     <= in_t[in_rd];
        issue_id <= in_id[in_rd];
      end
    end
  end

  // token/id pipeline matching pcalc latency; only v0 cycles inject a (possibly bubble) token
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tok_sr <= '0;
      for (int i = 1; i <= PCALC_LAT; i++) id_sr[i] <= '0;
    end else begin
      tok_sr[1] <= v0 & issue_tok;
      id_sr[1]  <= issue_id;
      for (int i = 2; i <= PCALC_LAT; i++) begin
        tok_sr[i] <= tok_sr[i-1];
        id_sr[i]  <= id_sr[i-1];
      end
    end
  end

  // result FIFO data write when a real token meets valid pcalc output
  always_ff @(posedge clk) begin
    if (res_push) begin
      res_pos[res_wr] <= pc_pos;
      res_idm[res_wr] <= id_sr[PCALC_LAT];
    end
  end

  // result FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_wr  <= '0;
      res_rd  <= '0;
      res_cnt <= '0;
    end else begin
      if (res_push) res_wr <= res_wr + RW'(1);
      if (res_pop)  res_rd <= res_rd + RW'(1);
      case ({res_push, res_pop})
        2'b10:   res_cnt <= res_cnt + (RW+1)'(1);
        2'b01:   res_cnt <= res_cnt - (RW+1)'(1);
        default: res_cnt <= res_cnt;
      endcase
    end
  end

  // credits reserve result slots: taken at issue, returned when a result leaves
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit <= (RW+1)'(RES_DEPTH);
    end else begin
      case ({issue, res_pop})
        2'b10:   credit <= credit - (RW+1)'(1);
        2'b01:   credit <= credit + (RW+1)'(1);
        default: credit <= credit;
      endcase
    end
  end

endmodule

// File: tb/tb_pcalc_issue.sv
// tb_pcalc_issue: directed bench for pcalc_issue with a behavioural pcalc model,
// an acceptance-order scoreboard and literal checks on hand-computed results.
module tb_pcalc_issue;

  localparam int DEPTH     = 4;
  localparam int RES_DEPTH = 4;
  localparam int PCALC_LAT = 12;
  localparam int ID_W      = 8;

  localparam logic [31:0] F0 = 32'h0000_0000;
  localparam logic [31:0] F1 = 32'h3f80_0000;
  localparam logic [31:0] F2 = 32'h4000_0000;
  localparam logic [31:0] F3 = 32'h4040_0000;
  localparam logic [31:0] F6 = 32'h40c0_0000;
  localparam logic [31:0] F9 = 32'h4110_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ray_valid = 1'b0;
  logic            ray_ready;
  logic [191:0]    ray_in = '0;
  logic [31:0]     t_in = '0;
  logic [ID_W-1:0] id_in = '0;
  logic [191:0]    pc_vec;
  logic [31:0]     pc_t;
  logic            v0, v1, v2;
  logic [95:0]     pc_pos = '0;
  logic            pos_valid;
  logic            pos_ready = 1'b1;
  logic [95:0]     pos_out;
  logic [ID_W-1:0] pos_id;

  pcalc_issue #(
    .DEPTH(DEPTH), .RES_DEPTH(RES_DEPTH), .PCALC_LAT(PCALC_LAT), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ray_valid(ray_valid), .ray_ready(ray_ready),
    .ray_in(ray_in), .t_in(t_in), .id_in(id_in),
    .pc_vec(pc_vec), .pc_t(pc_t), .v0(v0), .v1(v1), .v2(v2),
    .pc_pos(pc_pos),
    .pos_valid(pos_valid), .pos_ready(pos_ready),
    .pos_out(pos_out), .pos_id(pos_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int ph     = 0;

  // model state
  logic [95+ID_W:0] exp_q[$];
  logic [223:0]     iss_q[$];
  logic [95+ID_W:0] delivered[$];
  int               issue_cycles[$];
  logic [223:0]     last_win = '0;
  int               issue_count = 0;
  int               last_issue_cyc = 0;
  int               accept_cyc = 0;
  int               outstanding = 0;
  logic [2:0]       exp_strobe;
  bit               rand_ready = 1'b0;
  logic [95:0]      dl [0:PCALC_LAT];

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic failNote(input string name, input string detail);
    checks++;
    fails++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  // float32 <-> real helpers (normal numbers and zero are all this bench uses)
  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:23] == 8'd0) return 0.0;
    d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fl(input int x);
    return r2f(real'(x));
  endfunction

  function automatic logic [191:0] mkVec(input logic [31:0] ox, oy, oz, dx, dy, dz);
    return {ox, oy, oz, dx, dy, dz};
  endfunction

  // pos = origin + t*dir, component by component
  function automatic logic [95:0] calcPos(input logic [191:0] vec, input logic [31:0] t);
    logic [95:0] p;
    for (int k = 0; k < 3; k++)
      p[95-32*k -: 32] = r2f(f2r(vec[191-32*k -: 32]) + f2r(t) * f2r(vec[95-32*k -: 32]));
    return p;
  endfunction

  function automatic logic [191:0] genVec(input int n);
    return mkVec(fl(n), fl(n+1), fl(2), fl(1), fl(n % 3), fl(2));
  endfunction

  function automatic logic [31:0] genT(input int n);
    return fl(n % 4 + 1);
  endfunction

  // cycle counter and reference phase
  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) ph = 0;
    else      ph = (ph + 1) % 3;
  end

  // pcalc model: operands seen at v0 appear on pc_pos PCALC_LAT cycles later, junk otherwise
  initial for (int i = 0; i <= PCALC_LAT; i++) dl[i] = {3{32'hdeadbeef}};

  always @(negedge clk) begin
    for (int i = PCALC_LAT; i > 0; i--) dl[i] = dl[i-1];
    dl[0]  = v0 ? calcPos(pc_vec, pc_t) : {3{32'hdeadbeef}};
    pc_pos = dl[PCALC_LAT];
  end

  // random downstream backpressure when enabled
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      pos_ready = 1'($urandom_range(0, 1));
    end
  end

  // compare process: strobes, issue order, window stability, results and outstanding bound
  always @(negedge clk) begin
    exp_strobe = (ph == 0) ? 3'b100 : (ph == 1) ? 3'b010 : 3'b001;
    checkOutput("phase_strobes", {v0, v1, v2}, exp_strobe);
    if (!rst) begin
      exp_q.delete();
      iss_q.delete();
      last_win    = '0;
      outstanding = 0;
    end else begin
      if (ray_valid && ray_ready) begin
        exp_q.push_back({calcPos(ray_in, t_in), id_in});
        iss_q.push_back({ray_in, t_in});
        accept_cyc = cyc;
      end
      if (v0) begin
        if ({pc_vec, pc_t} != last_win) begin
          issue_count++;
          last_issue_cyc = cyc;
          issue_cycles.push_back(cyc);
          outstanding++;
          if (iss_q.size() == 0) failNote("unexpected_issue", $sformatf("pc_t=%h with nothing queued", pc_t));
          else checkOutput("issue_order", {pc_vec, pc_t}, iss_q.pop_front());
          last_win = {pc_vec, pc_t};
        end
      end else begin
        checkOutput("window_hold", {pc_vec, pc_t}, last_win);
      end
      if (pos_valid) begin
        if (exp_q.size() == 0) begin
          failNote("spurious_pos_valid", $sformatf("pos_id=%h with no result expected", pos_id));
        end else if (pos_ready) begin
          checkOutput("result_pos_id", {pos_out, pos_id}, exp_q.pop_front());
          delivered.push_back({pos_out, pos_id});
          outstanding--;
        end
      end
      checkOutput("outstanding_bound", outstanding <= RES_DEPTH, 1'b1);
    end
  end

  // offer one ray and hold it until accepted; returns aligned just after a posedge
  task automatic applyStimulus(input logic [191:0] vec, input logic [31:0] t, input logic [ID_W-1:0] id);
    bit ok;
    ok = 1'b0;
    ray_in = vec;
    t_in = t;
    id_in = id;
    ray_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (ray_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    ray_valid = 1'b0;
    if (!ok) failNote("ray_accept_timeout", $sformatf("id %h never accepted", id));
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitIssues(input int target, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (issue_count >= target) ok = 1'b1;
    end
    if (!ok) failNote(name, $sformatf("issue count %0d, wanted %0d", issue_count, target));
    @(posedge clk);
    #1;
  endtask

  task automatic waitDelivered(input int target, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (delivered.size() >= target) ok = 1'b1;
    end
    if (!ok) failNote(name, $sformatf("delivered %0d, wanted %0d", delivered.size(), target));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ic0, base, rise, v0c, n;
    bit seen;

    // reset state
    rst = 1'b0;
    waitCycles(3);
    checkOutput("reset_pos_valid", pos_valid, 1'b0);
    checkOutput("reset_pos_out", pos_out, 96'd0);
    checkOutput("reset_pos_id", pos_id, 8'd0);
    checkOutput("reset_ray_ready", ray_ready, 1'b1);
    checkOutput("reset_strobes", {v0, v1, v2}, 3'b100);
    checkOutput("reset_pc_vec_t", {pc_vec, pc_t}, 224'd0);
    rst = 1'b1;
    waitCycles(4);

    // 1: single ray, latency and literal result
    $display("[TB] single ray");
    ic0 = issue_count;
    base = delivered.size();
    applyStimulus(mkVec(F0, F0, F0, F1, F1, F1), F1, 8'h01);
    waitIssues(ic0 + 1, 10, "single_issue_timeout");
    v0c = last_issue_cyc;
    checkOutput("accept_to_v0_in_2_to_4", (v0c - accept_cyc >= 2) && (v0c - accept_cyc <= 4), 1'b1);
    seen = 1'b0;
    rise = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (pos_valid) begin
        seen = 1'b1;
        rise = cyc;
        checkOutput("single_pos_out", pos_out, {F1, F1, F1});
        checkOutput("single_pos_id", pos_id, 8'h01);
      end
    end
    if (!seen) failNote("single_pos_valid_timeout", "pos_valid never rose");
    else checkOutput("v0_to_pos_valid", rise - v0c, PCALC_LAT + 1);
    @(posedge clk);
    #1;
    waitCycles(20);
    checkOutput("single_exactly_one", delivered.size() - base, 1);

    // 4: bubbles between isolated rays
    $display("[TB] isolated rays with bubbles");
    base = delivered.size();
    for (int k = 0; k < 4; k++) begin
      n = 10 + k;
      applyStimulus(genVec(n), genT(n), ID_W'(n));
      waitCycles(9);
    end
    waitCycles(40);
    checkOutput("bubble_all_delivered", delivered.size() - base, 4);
    checkOutput("bubble_credit_idle", dut.credit, RES_DEPTH);

    // 2: four back-to-back rays, literal results and issue spacing
    $display("[TB] back-to-back rays");
    base = delivered.size();
    ic0 = issue_cycles.size();
    applyStimulus(mkVec(F0, F0, F0, F1, F1, F1), F1, 8'h01);
    applyStimulus(mkVec(F1, F1, F1, F1, F1, F1), F1, 8'h02);
    applyStimulus(mkVec(F3, F2, F1, F1, F1, F1), F0, 8'h03);
    applyStimulus(mkVec(F1, F2, F3, F1, F2, F3), F2, 8'h04);
    waitDelivered(base + 4, 80, "b2b_delivery_timeout");
    if (delivered.size() >= base + 4) begin
      checkOutput("b2b_res1", delivered[base],   {F1, F1, F1, 8'h01});
      checkOutput("b2b_res2", delivered[base+1], {F2, F2, F2, 8'h02});
      checkOutput("b2b_res3", delivered[base+2], {F3, F2, F1, 8'h03});
      checkOutput("b2b_res4", delivered[base+3], {F3, F6, F9, 8'h04});
    end
    if (issue_cycles.size() >= ic0 + 4) begin
      for (int k = 0; k < 3; k++)
        checkOutput("b2b_issue_spacing", issue_cycles[ic0+k+1] - issue_cycles[ic0+k], 3);
    end else begin
      failNote("b2b_issue_count", $sformatf("only %0d issues seen", issue_cycles.size() - ic0));
    end

    // 3: backpressure, credits limit issue to RES_DEPTH
    $display("[TB] backpressure");
    pos_ready = 1'b0;
    base = delivered.size();
    ic0 = issue_count;
    for (int k = 0; k < 8; k++) begin
      n = 20 + k;
      applyStimulus(genVec(n), genT(n), ID_W'(n));
    end
    @(negedge clk);
    checkOutput("bp_ready_low_when_full", ray_ready, 1'b0);
    @(posedge clk);
    #1;
    waitCycles(30);
    checkOutput("bp_issue_count", issue_count - ic0, RES_DEPTH);
    checkOutput("bp_ready_still_low", ray_ready, 1'b0);
    checkOutput("bp_pos_valid_held", pos_valid, 1'b1);
    pos_ready = 1'b1;
    waitDelivered(base + 8, 200, "bp_delivery_timeout");
    waitCycles(20);
    checkOutput("bp_all_delivered", delivered.size() - base, 8);
    checkOutput("bp_credit_idle", dut.credit, RES_DEPTH);

    // 6: random downstream readiness under sustained load
    $display("[TB] random pos_ready");
    base = delivered.size();
    rand_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      n = 30 + k;
      applyStimulus(genVec(n), genT(n), ID_W'(n));
    end
    waitCycles(60);
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    pos_ready = 1'b1;
    waitDelivered(base + 12, 200, "rand_delivery_timeout");
    waitCycles(20);
    checkOutput("rand_all_delivered", delivered.size() - base, 12);
    checkOutput("rand_credit_idle", dut.credit, RES_DEPTH);

    // 5: reset with rays in flight and queued
    $display("[TB] reset mid-flight");
    ic0 = issue_count;
    for (int k = 0; k < 5; k++) begin
      n = 50 + k;
      applyStimulus(genVec(n), genT(n), ID_W'(n));
    end
    waitIssues(ic0 + 3, 30, "rst_issue_timeout");
    checkOutput("rst_inflight_before", {exp_q.size() == 5, pos_valid}, 2'b10);
    rst = 1'b0;
    #1;
    checkOutput("rst_pos_valid", pos_valid, 1'b0);
    checkOutput("rst_ray_ready", ray_ready, 1'b1);
    checkOutput("rst_strobes", {v0, v1, v2}, 3'b100);
    @(posedge clk);
    #1;
    rst = 1'b1;
    base = delivered.size();
    waitCycles(40);
    checkOutput("rst_no_stale_results", delivered.size() - base, 0);
    checkOutput("rst_credit_restored", dut.credit, RES_DEPTH);
    applyStimulus(genVec(60), genT(60), 8'h09);
    waitDelivered(base + 1, 40, "rst_next_ray_timeout");
    if (delivered.size() >= base + 1)
      checkOutput("rst_next_ray", delivered[base], {32'h4274_0000, 32'h4274_0000, 32'h4080_0000, 8'h09});

    waitCycles(5);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pcalc_issue.md
Name: pcalc_issue

Overview:
- Issue/collect stage wrapped around pcalc, which computes pos = origin + t*dir.
- Upstream side: accepts rays (ray_vec_t, t, ray id) over a valid/ready handshake into a small FIFO.
- Generates the 3-phase v0/v1/v2 strobes that pcalc requires and presents one ray per 3-cycle window.
- Tracks each issued ray through pcalc's fixed latency, captures pos with its id into a credit-protected result FIFO, and offers it downstream on a valid/ready handshake.

Parameters:
DEPTH, 4, input FIFO entries (power of 2, >=2)
RES_DEPTH, 4, result FIFO entries; also the initial issue credit count (power of 2, >=2)
PCALC_LAT, 12, cycles from a window's v0 cycle to pcalc pos valid for that ray (>=1)
ID_W, 8, ray id width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
ray_valid  in  1  upstream ray offered
ray_ready  out  1  input FIFO can accept
ray_in  in  192  ray_vec_t {origin, dir}
t_in  in  32  float_t hit distance
id_in  in  ID_W  ray id
pc_vec  out  192  ray to pcalc vec
pc_t  out  32  t to pcalc
v0  out  1  phase 0 strobe to pcalc
v1  out  1  phase 1 strobe to pcalc
v2  out  1  phase 2 strobe to pcalc
pc_pos  in  96  vector_t pos from pcalc
pos_valid  out  1  result available
pos_ready  in  1  downstream accepts result
pos_out  out  96  vector_t position
pos_id  out  ID_W  id of pos_out

Behaviour:
Phase counter:
- 2-bit, sequence 0->1->2->0, reset value 0.
- v0 = (cnt==0), v1 = (cnt==1), v2 = (cnt==2). Exactly one strobe is high every cycle, including during reset (v0=1).

Input FIFO:
- ray_ready = !in_full. It is not combinationally dependent on an issue in the same cycle.
- Push on ray_valid & ray_ready.
- When full, a push and a pop in the same cycle never both occur, because ready is low.

Issue:
- Decision is made in a cycle with cnt==2.
- Issue iff FIFO non-empty and credit>0: pop the head, load pc_vec/pc_t/issue_id registers, set issue_tok=1, credit-1.
- Otherwise issue_tok=0 and pc_vec/pc_t hold their previous values (bubble window).
- pc_vec/pc_t are stable for the whole following v0,v1,v2 window.
- Reset value: pc_vec=0, pc_t=0.

Latency tracking:
- Shift register of PCALC_LAT+1 stages carrying {tok, id}. Stage 0 is loaded in the v0 cycle from {issue_tok, issue_id}.
- When the token reaches stage PCALC_LAT (pc_pos valid), write {pc_pos, id} into the result FIFO if tok=1.
- Bubble tokens write nothing.

Result FIFO / output:
- pos_valid = !res_empty; pos_out/pos_id = head entry.
- Pop on pos_valid & pos_ready.
- Reset values: pos_valid=0, pos_out=0, pos_id=0.

Credits:
- Counter reset to RES_DEPTH.
- Decrement on issue, increment on output pop. Both in the same cycle means no change.
- Credit counter never exceeds RES_DEPTH and never underflows, so the result FIFO never overflows.

Latency (idle block, pos_ready=1):
- Acceptance to the v0 of its issue window is 2..4 cycles, depending on phase.
- pos_valid rises exactly PCALC_LAT+1 cycles after that v0 cycle.

Ordering and throughput:
- Results leave in acceptance order.
- Maximum throughput is 1 ray per 3 cycles.

Reset:
- Asserting rst at any time clears both FIFOs, the shift register, credits (to RES_DEPTH) and the phase counter.
- In-flight rays are discarded; no pos_valid pulse follows reset release until a new ray completes.

Test Plan:
1. Single ray: org (0,0,0), dir (1,1,1), t=1.0, id 0x01 -> pos_out=(1.0,1.0,1.0), pos_id=0x01, pos_valid exactly PCALC_LAT+1 cycles after its v0; exactly one result.
2. Back-to-back 4 rays (org (0,0,0),(1,1,1),(3,2,1),(1,2,3); dir (1,1,1),(1,1,1),(1,1,1),(1,2,3); t 1,1,0,2; ids 1..4), ray_valid held high -> results (1,1,1),(2,2,2),(3,2,1),(3,6,9) in id order 1..4, successive v0 issues exactly 3 cycles apart.
3. Backpressure: pos_ready=0, push 8 rays -> exactly RES_DEPTH=4 issue, input FIFO fills, ray_ready falls after 4 more accepts; release pos_ready -> all 8 delivered in order, none lost or duplicated.
4. Bubbles: single ray every 10 cycles -> pc_vec/pc_t held between issues, no spurious pos_valid, credit returns to 4 when idle.
5. Reset mid-flight: 3 rays in pcalc plus 2 queued, pull rst low for 1 cycle -> pos_valid=0, ray_ready=1, v0=1 immediately; no stale results afterwards; next ray id 0x09 completes normally.
6. Simultaneous issue and output pop with credit=0 -> credit remains consistent (issue only proceeds once credit>0), checked by assertion over random pos_ready.
